// File: rtl/uart_com_port.sv
// 8N1 UART endpoint for the memory controller's COM interface: TX serialiser,
// RX deserialiser with a one-byte holding register and ack-edge handshake.
module uart_com_port #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       enable_com_write,
  input  logic [7:0] com_data_out,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  // Clocks per bit; the mid-bit sampling scheme needs DIV >= 4.
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic             tx_tick;
  logic             tx_accept;

  always_comb begin
    tx_state_nxt    = tx_state;
    tx_tick         = (tx_cnt == '0);
    tx_accept       = 1'b0;
    uart_txd        = 1'b1;
    com_write_ready = 1'b0;
    case (tx_state)
      S_IDLE: begin
        com_write_ready = 1'b1;
        if (enable_com_write) begin
          tx_accept    = 1'b1;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        uart_txd = 1'b0;
        if (tx_tick) tx_state_nxt = S_DATA;
      end
      S_DATA: begin
        uart_txd = tx_sh[0];
        if (tx_tick && tx_bit == 3'd7) tx_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // The bit timer is held at full count in IDLE so every state lasts exactly DIV clocks.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= CNT_FULL;
      tx_bit   <= 3'd0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= CNT_FULL;
      else                               tx_cnt <= tx_cnt - CNT_ONE;
      if (tx_state == S_IDLE)                tx_bit <= 3'd0;
      else if (tx_state == S_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk50M) begin
    if (tx_accept)                         tx_sh <= com_data_out;
    else if (tx_state == S_DATA && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
  end

  // RX synchroniser: p0/p1 form the 2-FF chain, p2 is the previous synchronised value.
  logic rxd_p0, rxd_p1, rxd_p2;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  state_t           rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_tick;
  logic             rx_fall;
  logic             rx_load;
  logic             rx_ferr;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tick      = (rx_cnt == '0);
    rx_fall      = rxd_p2 & ~rxd_p1;
    rx_load      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_fall) rx_state_nxt = S_START;
      end
      S_START: begin
        if (rx_tick) rx_state_nxt = rxd_p1 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_tick && rx_bit == 3'd7) rx_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave mid stop bit so the next start edge is never missed.
        if (rx_tick) begin
          rx_state_nxt = S_IDLE;
          rx_load      = rxd_p1;
          rx_ferr      = ~rxd_p1;
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= CNT_HALF;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == S_IDLE) rx_cnt <= CNT_HALF;
      else if (rx_tick)       rx_cnt <= CNT_FULL;
      else                    rx_cnt <= rx_cnt - CNT_ONE;
      if (rx_state == S_IDLE)                rx_bit <= 3'd0;
      else if (rx_state == S_DATA && rx_tick) rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rx_state == S_DATA && rx_tick) rx_sh <= {rxd_p1, rx_sh[7:1]};
  end

  // Holding register and handshake: a byte load outranks a same-cycle ack edge.
  logic ack_d;
  logic ack_rise;

  assign ack_rise = int_com_ack & ~ack_d;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      ack_d          <= 1'b0;
      com_data_in    <= 8'h00;
      com_read_ready <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_frame_err   <= 1'b0;
    end else begin
      ack_d        <= int_com_ack;
      rx_frame_err <= rx_ferr;
      if (rx_load) begin
        com_data_in    <= rx_sh;
        com_read_ready <= 1'b1;
        if (com_read_ready) rx_overrun <= 1'b1;
      end else if (ack_rise) begin
        com_read_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_com_port.sv
// Directed bench for uart_com_port: TX framing, RX holding register,
// ack-edge handshake, overrun, glitch/frame-error handling and reset abort.
module tb_uart_com_port;

  localparam int DIV   = 434;
  localparam int FRAME = 10 * DIV;

  logic       clk50M = 1'b0;
  logic       rst;
  logic       enable_com_write;
  logic [7:0] com_data_out;
  logic       com_write_ready;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       int_com_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       uart_txd;
  logic       uart_rxd;
  logic       rxd_drv;
  logic       loopback;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_count = 0;
  logic rdy_before_stop;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  always #10 clk50M = ~clk50M;

  uart_com_port dut (
    .clk50M           (clk50M),
    .rst              (rst),
    .enable_com_write (enable_com_write),
    .com_data_out     (com_data_out),
    .com_write_ready  (com_write_ready),
    .com_data_in      (com_data_in),
    .com_read_ready   (com_read_ready),
    .int_com_ack      (int_com_ack),
    .rx_overrun       (rx_overrun),
    .rx_frame_err     (rx_frame_err),
    .uart_txd         (uart_txd),
    .uart_rxd         (uart_rxd)
  );

  // Counts clock cycles during which rx_frame_err is high.
  always @(posedge clk50M) begin
    if (rx_frame_err === 1'b1) fe_count <= fe_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic tx_req(input logic [7:0] b);
    enable_com_write = 1'b1;
    com_data_out     = b;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    com_data_out     = 8'h00;
  endtask

  // Called one cycle after the request; follows the whole frame bit by bit.
  task automatic tx_watch(input logic [7:0] b, input int inject_at);
    int   bad_txd = 0;
    int   bad_rdy = 0;
    int   bitn;
    logic exp_txd;
    for (int i = 0; i < FRAME; i++) begin
      bitn = i / DIV;
      if (bitn == 0)      exp_txd = 1'b0;
      else if (bitn == 9) exp_txd = 1'b1;
      else                exp_txd = b[bitn-1];
      if (uart_txd !== exp_txd) bad_txd++;
      if (com_write_ready !== 1'b0) bad_rdy++;
      if (inject_at >= 0 && i == inject_at) begin
        enable_com_write = 1'b1;
        com_data_out     = 8'hFF;
      end else if (inject_at >= 0 && i == inject_at + 1) begin
        enable_com_write = 1'b0;
        com_data_out     = 8'h00;
      end
      @(negedge clk50M);
    end
    check("tx_txd_bad_cycles", 32'(bad_txd), 32'd0);
    check("tx_busy_bad_cycles", 32'(bad_rdy), 32'd0);
    check("tx_ready_after_frame", 32'(com_write_ready), 32'd1);
    check("tx_line_idle_after", 32'(uart_txd), 32'd1);
  endtask

  task automatic rx_bit(input logic v);
    rxd_drv = v;
    repeat (DIV) @(negedge clk50M);
  endtask

  // nbits < 8 aborts the frame after that many data bits, leaving the line as is.
  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int nbits);
    rx_bit(1'b0);
    for (int k = 0; k < nbits; k++) rx_bit(b[k]);
    if (nbits == 8) begin
      rdy_before_stop = com_read_ready;
      rx_bit(stop_bit);
      rxd_drv = 1'b1;
    end
  endtask

  initial begin
    int fe0;
    int bad;
    rst              = 1'b1;
    enable_com_write = 1'b0;
    com_data_out     = 8'h00;
    int_com_ack      = 1'b0;
    rxd_drv          = 1'b1;
    loopback         = 1'b0;
    rdy_before_stop  = 1'b0;
    tick(3);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_write_ready", 32'(com_write_ready), 32'd1);
    check("rst_data_in", 32'(com_data_in), 32'h00);
    check("rst_read_ready", 32'(com_read_ready), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // TX of 0x55 with exact bit timing
    tx_req(8'h55);
    tx_watch(8'h55, -1);
    tick(5);

    // Request mid-frame is ignored and does not queue a second frame
    tx_req(8'hA0);
    tx_watch(8'hA0, 1000);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (uart_txd !== 1'b1 || com_write_ready !== 1'b1) bad++;
      @(negedge clk50M);
    end
    check("tx_no_late_frame", 32'(bad), 32'd0);

    // RX 0xA5 then ack edge
    fe0 = fe_count;
    rx_send(8'hA5, 1'b1, 8);
    check("rx_ready_before_stop", 32'(rdy_before_stop), 32'd0);
    check("rx_data_a5", 32'(com_data_in), 32'hA5);
    check("rx_ready_a5", 32'(com_read_ready), 32'd1);
    check("rx_no_ferr_a5", 32'(fe_count - fe0), 32'd0);
    int_com_ack = 1'b1;
    check("rx_ready_at_ack", 32'(com_read_ready), 32'd1);
    tick(1);
    check("rx_ready_after_ack", 32'(com_read_ready), 32'd0);

    // Ack held high: later bytes are not cleared, second byte overruns
    tick(10);
    rx_send(8'h3C, 1'b1, 8);
    tick(5);
    check("rx_data_3c", 32'(com_data_in), 32'h3C);
    check("rx_ready_3c_held_ack", 32'(com_read_ready), 32'd1);
    check("rx_overrun_3c", 32'(rx_overrun), 32'd0);
    rx_send(8'hC3, 1'b1, 8);
    tick(2);
    check("rx_data_c3", 32'(com_data_in), 32'hC3);
    check("rx_ready_c3", 32'(com_read_ready), 32'd1);
    check("rx_overrun_c3", 32'(rx_overrun), 32'd1);
    int_com_ack = 1'b0;
    tick(2);
    int_com_ack = 1'b1;
    tick(2);
    check("rx_ready_cleared", 32'(com_read_ready), 32'd0);
    check("rx_overrun_sticky", 32'(rx_overrun), 32'd1);
    int_com_ack = 1'b0;

    // Short glitch, then a frame with a bad stop bit
    fe0 = fe_count;
    rxd_drv = 1'b0;
    tick(100);
    rxd_drv = 1'b1;
    tick(800);
    check("glitch_no_ready", 32'(com_read_ready), 32'd0);
    check("glitch_no_ferr", 32'(fe_count - fe0), 32'd0);
    rx_send(8'h12, 1'b0, 8);
    tick(5);
    check("ferr_one_cycle", 32'(fe_count - fe0), 32'd1);
    check("ferr_no_ready", 32'(com_read_ready), 32'd0);
    check("ferr_data_kept", 32'(com_data_in), 32'hC3);

    // Reset in the middle of a TX and an RX frame
    tx_req(8'hF0);
    rx_send(8'h5A, 1'b1, 3);
    check("pre_rst_tx_busy", 32'(com_write_ready), 32'd0);
    rst     = 1'b1;
    rxd_drv = 1'b1;
    tick(1);
    check("mid_rst_txd", 32'(uart_txd), 32'd1);
    check("mid_rst_write_ready", 32'(com_write_ready), 32'd1);
    check("mid_rst_data_in", 32'(com_data_in), 32'h00);
    check("mid_rst_read_ready", 32'(com_read_ready), 32'd0);
    check("mid_rst_overrun", 32'(rx_overrun), 32'd0);
    check("mid_rst_frame_err", 32'(rx_frame_err), 32'd0);
    rst = 1'b0;
    tick(5);

    // Clean 0x81 in both directions via loopback
    fe0      = fe_count;
    loopback = 1'b1;
    tick(2);
    tx_req(8'h81);
    tx_watch(8'h81, -1);
    tick(20);
    check("loop_data_81", 32'(com_data_in), 32'h81);
    check("loop_ready_81", 32'(com_read_ready), 32'd1);
    check("loop_overrun_81", 32'(rx_overrun), 32'd0);
    check("loop_no_ferr", 32'(fe_count - fe0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
